// File: rtl/regfile_pkg.sv
// regfile_pkg: shared enums for the multi-port register file
package regfile_pkg;
  typedef enum logic {INIT_ZERO, INIT_INDEX} init_mode_e;
  typedef enum logic {INIT, READY} rf_state_e;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port, packed read ports and status of the register file
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);
  logic                  reg_write;
  logic [AW-1:0]         write_reg;
  logic [XLEN-1:0]       write_data;
  logic [NREAD*AW-1:0]   read_reg;
  logic [NREAD*XLEN-1:0] read_data;
  logic                  init_busy;
  logic                  write_dropped;
  modport master (
    output reg_write, write_reg, write_data, read_reg,
    input  read_data, init_busy, write_dropped
  );
  modport slave (
    input  reg_write, write_reg, write_data, read_reg,
    output read_data, init_busy, write_dropped
  );
endinterface

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: post-reset fill sequencer, one register per clock
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         NREGS     = 32,
  parameter init_mode_e INIT_MODE = INIT_INDEX,
  localparam int        AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_write,
  output logic            init_busy,
  output logic            write_dropped,
  output logic            init_we,
  output logic [AW-1:0]   init_addr,
  output logic [XLEN-1:0] init_data
);
  rf_state_e     state;
  logic [AW-1:0] ptr;
  // walk ptr across the file, leave INIT on the last register; flag writes lost meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      ptr           <= '0;
      init_busy     <= 1'b1;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= (state == INIT) && reg_write;
      if (state == INIT) begin
        ptr <= (ptr == AW'(NREGS - 1)) ? ptr : ptr + 1'b1;
        if (ptr == AW'(NREGS - 1)) begin
          state     <= READY;
          init_busy <= 1'b0;
        end
      end
    end
  end
  assign init_we   = (state == INIT);
  assign init_addr = ptr;
  assign init_data = (INIT_MODE == INIT_INDEX) ? XLEN'(ptr) : '0;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, x0 hardwired, optional write bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         NREGS     = 32,
  parameter int         NREAD     = 2,
  parameter bit         BYPASS    = 1'b1,
  parameter init_mode_e INIT_MODE = INIT_INDEX,
  localparam int        AW        = $clog2(NREGS)
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  logic [XLEN-1:0]       mem [NREGS];
  logic                  init_busy, init_we;
  logic [AW-1:0]         init_addr, wa;
  logic [XLEN-1:0]       init_data, wd;
  logic                  we;
  logic [NREAD*XLEN-1:0] rd;
  regfile_init_seq #(.XLEN(XLEN), .NREGS(NREGS), .INIT_MODE(INIT_MODE)) u_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_write     (bus.reg_write),
    .init_busy     (init_busy),
    .write_dropped (bus.write_dropped),
    .init_we       (init_we),
    .init_addr     (init_addr),
    .init_data     (init_data)
  );
  assign we = init_we || (!init_busy && bus.reg_write && bus.write_reg != '0);
  assign wa = init_we ? init_addr : bus.write_reg;
  assign wd = init_we ? init_data : bus.write_data;
  // storage has no reset; the sequencer is what gives it defined contents
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.read_reg[p*AW +: AW];
    assign rd[p*XLEN +: XLEN] = (init_busy || ra == '0) ? '0 :
                                (BYPASS && bus.reg_write && bus.write_reg == ra) ? bus.write_data : mem[ra];
  end
  assign bus.read_data = rd;
  assign bus.init_busy = init_busy;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core datapath, sitting between decode (read addresses) and writeback (write port). It generalises the register file with a configurable width, depth and read-port count. Register 0 is hardwired to zero, and an optional same-cycle write-to-read bypass is provided. A post-reset initialisation sequencer loads every register with a defined value, one register per cycle, and reports when the file is ready.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, ≥ 2
- NREAD, 2, number of independent read ports, ≥ 1
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data; 0 = returns the old contents
- INIT_MODE, INIT_INDEX, post-reset fill value: INIT_INDEX gives reg[i] = i; INIT_ZERO gives 0
- AW, derived, $clog2(NREGS); not overridable
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_write  in  1  write enable for the write port
- write_reg  in  AW  write address
- write_data  in  XLEN  write data
- read_reg  in  NREAD*AW  packed read addresses; port p uses bits [p*AW +: AW]
- read_data  out  NREAD*XLEN  packed read data; port p uses bits [p*XLEN +: XLEN]
- init_busy  out  1  high while the initialisation sequencer runs
- write_dropped  out  1  one-cycle pulse when reg_write=1 is ignored during init

## Operation
- FSM states are INIT and READY. Asserting rst_n=0 forces INIT, sets ptr=0 and clears write_dropped, all asynchronously.
- In INIT, each clock writes reg[ptr] with the fill value (INIT_INDEX: ptr zero-extended to XLEN; INIT_ZERO: 0), then increments ptr.
- When ptr == NREGS-1 is written, the FSM moves to READY on the same edge. It stays in READY until the next reset.
- In INIT, external writes are ignored. If reg_write=1 on a clock edge during INIT, write_dropped pulses high for the following cycle.
- In INIT, all read_data ports output 0.
- In READY, when reg_write=1 and write_reg≠0, reg[write_reg] takes write_data at the clock edge. Writes to address 0 are discarded without a pulse.
- Read ports are combinational and independent; several ports may read the same address.
- Address 0 always reads 0, regardless of BYPASS or write activity.
- With BYPASS=1 in READY, each port where reg_write=1, write_reg==read addr and the address ≠ 0 returns write_data in the same cycle.
- With BYPASS=0, a read returns the pre-edge contents.
- Memory contents are not reset asynchronously. The sequencer is the only clearing mechanism.

## Timing
- Reset values: init_busy=1, write_dropped=0, read_data=0.
- After rst_n deasserts, init_busy stays high for exactly NREGS rising edges, then falls. The first normal write is accepted on edge NREGS+1.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 edge with BYPASS=0.
- Read latency: combinational, so valid in the same cycle the address is applied.
- Reset asserted mid-INIT or in READY aborts immediately and returns to INIT with ptr=0. Register contents are undefined until the re-init completes.
- ptr holds AW bits and never wraps, because the FSM leaves INIT at NREGS-1.

## Structure
- Shared package regfile_pkg holds:
  - the init_mode_e enum (INIT_ZERO, INIT_INDEX);
  - the rf_state_e enum (INIT, READY).
- Sub-module regfile_init_seq contains the FSM, ptr, init_busy and write_dropped. It outputs init_we, init_addr and init_data.
- The top level muxes those sequencer outputs against the external write port.
- The top level also contains the storage array and NREAD generate-loop read ports with bypass and zero logic.

## Test plan
- Reset release, defaults → init_busy high for 32 edges; afterwards ports 0 and 1 reading x5 and x31 return 5 and 31.
- INIT_ZERO, NREAD=3 → after init, x1, x17 and x30 all read 0; init_busy falls after edge 32.
- READY: write x7=0xDEADBEEF while port 1 reads x7 → BYPASS=1 gives 0xDEADBEEF in the same cycle; BYPASS=0 gives 7, then 0xDEADBEEF after the edge.
- Write x0=0xFFFFFFFF while both ports read x0 → both read 0 in the same cycle and after the edge; no write_dropped pulse.
- reg_write=1 to x3 at edge 10 of init → write_dropped pulses once; after init, x3 reads 3.
- Write x9=0x1234 in READY, then pulse rst_n low mid-cycle → init_busy rises immediately; after 32 edges, x9 reads 9.
